// File: rtl/nn_pkg.sv
// Shared constants and elaboration helpers for the conv-layer datapath.
package nn_pkg;

    localparam int NN_DATA_W = 16;
    localparam int NN_ACC_W  = 32;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // in_last beat capture edge to conv_dout_vld edge
    function automatic int pconv_latency(input int ch);
        return 3 + clog2(ch);
    endfunction

endpackage

// File: rtl/padd_tree.sv
// Pipelined pairwise adder tree, one register level per halving, with a
// valid flag and a free-form sideband delayed by the same depth.
module padd_tree
    import nn_pkg::*;
#(
    parameter int W   = 32,
    parameter int CNT = 6,
    parameter int SB  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    input  logic [SB-1:0]    in_sb,
    input  logic [CNT*W-1:0] in_data,
    output logic             out_vld,
    output logic [SB-1:0]    out_sb,
    output logic [W-1:0]     out_sum
);

    localparam int T = clog2(CNT);

    if (T == 0) begin : g_pass
        assign out_vld = in_vld;
        assign out_sb  = in_sb;
        assign out_sum = in_data;
    end else begin : g_tree
        // Each level is padded to 2*CNT entries of zero so an odd operand
        // simply adds to zero and passes through.
        logic [W-1:0]  leaf [2*CNT];
        logic [W-1:0]  node [T][2*CNT];
        logic [T-1:0]  vld_q;
        logic [SB-1:0] sb_q [T];

        always_comb begin
            for (int j = 0; j < 2*CNT; j++) leaf[j] = '0;
            for (int j = 0; j < CNT; j++) leaf[j] = in_data[j*W +: W];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int l = 0; l < T; l++) begin
                    for (int j = 0; j < 2*CNT; j++) node[l][j] <= '0;
                    sb_q[l] <= '0;
                end
                vld_q <= '0;
            end else begin
                for (int j = 0; j < CNT; j++)
                    node[0][j] <= leaf[2*j] + leaf[2*j+1];
                for (int l = 1; l < T; l++)
                    for (int j = 0; j < CNT; j++)
                        node[l][j] <= node[l-1][2*j] + node[l-1][2*j+1];
                vld_q[0] <= in_vld;
                sb_q[0]  <= in_sb;
                for (int l = 1; l < T; l++) begin
                    vld_q[l] <= vld_q[l-1];
                    sb_q[l]  <= sb_q[l-1];
                end
            end
        end

        assign out_vld = vld_q[T-1];
        assign out_sb  = sb_q[T-1];
        assign out_sum = node[T-1][0];
    end

endmodule

// File: rtl/pconv_unit_acc.sv
// Partial-convolution unit: CH-lane MAC with registered adder tree, multi-beat
// accumulation, then bias, arithmetic shift and ReLU/saturating clamp.
module pconv_unit_acc
    import nn_pkg::*;
#(
    parameter int N     = NN_DATA_W,
    parameter int CH    = 6,
    parameter int ACC_W = NN_ACC_W,
    parameter int MAX   = 127,
    parameter int RELU  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vld,
    input  logic              in_first,
    input  logic              in_last,
    input  logic [CH*N-1:0]   input_din,
    input  logic [CH*N-1:0]   weight_din,
    input  logic [ACC_W-1:0]  bias_din,
    input  logic [4:0]        shift_din,
    output logic [N-1:0]      conv_dout,
    output logic              conv_dout_vld
);

    localparam int SB = ACC_W + 7;
    localparam logic signed [ACC_W-1:0] CLAMP_HI = ACC_W'(MAX);
    localparam logic signed [ACC_W-1:0] CLAMP_LO = (RELU != 0) ? '0 : ACC_W'(-MAX - 1);

    logic signed [2*N-1:0] a_ext, b_ext, prod;
    logic [CH*ACC_W-1:0]   prod_c, m_prod;
    logic                  m_vld;
    logic [SB-1:0]         m_sb;

    always_comb begin
        prod_c = '0;
        a_ext  = '0;
        b_ext  = '0;
        prod   = '0;
        for (int i = 0; i < CH; i++) begin
            a_ext = {{N{input_din[i*N+N-1]}}, input_din[i*N +: N]};
            b_ext = {{N{weight_din[i*N+N-1]}}, weight_din[i*N +: N]};
            prod  = a_ext * b_ext;
            prod_c[i*ACC_W +: ACC_W] = ACC_W'(prod);
        end
    end

    // first/last are qualified here so the tree sideband never carries a
    // stray flag from an idle cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_vld  <= 1'b0;
            m_sb   <= '0;
            m_prod <= '0;
        end else begin
            m_vld  <= in_vld;
            m_sb   <= {in_vld & in_first, in_vld & in_last, bias_din, shift_din};
            m_prod <= prod_c;
        end
    end

    logic             t_vld;
    logic [SB-1:0]    t_sb;
    logic [ACC_W-1:0] t_sum;

    padd_tree #(.W(ACC_W), .CNT(CH), .SB(SB)) u_tree (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (m_vld),
        .in_sb   (m_sb),
        .in_data (m_prod),
        .out_vld (t_vld),
        .out_sb  (t_sb),
        .out_sum (t_sum)
    );

    logic                    t_first, t_last;
    logic signed [ACC_W-1:0] t_bias;
    logic [4:0]              t_shift;

    assign t_first = t_sb[SB-1];
    assign t_last  = t_sb[SB-2];
    assign t_bias  = t_sb[5 +: ACC_W];
    assign t_shift = t_sb[4:0];

    logic signed [ACC_W-1:0] acc, a_bias;
    logic                    a_last;
    logic [4:0]              a_shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            a_last  <= 1'b0;
            a_bias  <= '0;
            a_shift <= '0;
        end else begin
            if (t_vld) acc <= (t_first ? '0 : acc) + t_sum;
            a_last  <= t_vld & t_last;
            a_bias  <= t_bias;
            a_shift <= t_shift;
        end
    end

    logic signed [ACC_W-1:0] biased, b_res;
    logic                    b_vld;

    assign biased = acc + a_bias;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_vld <= 1'b0;
            b_res <= '0;
        end else begin
            b_vld <= a_last;
            b_res <= biased >>> a_shift;
        end
    end

    logic [N-1:0] dout_c;

    always_comb begin
        dout_c = b_res[N-1:0];
        if (b_res > CLAMP_HI)      dout_c = CLAMP_HI[N-1:0];
        else if (b_res < CLAMP_LO) dout_c = CLAMP_LO[N-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conv_dout     <= '0;
            conv_dout_vld <= 1'b0;
        end else begin
            conv_dout_vld <= b_vld;
            if (b_vld) conv_dout <= dout_c;
        end
    end

endmodule
